// File: rtl/bt_seq_pkg.sv
// Shared definitions for the Bluetooth UART transmit sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bt_seq_pkg;

    // Sequencer states: one peripheral write, a settle gap, then status polling.
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETTLE,
        POLL,
        CHECK
    } bt_state_e;

    // Register map of the peripheral_bt register bus.
    localparam logic [1:0] BT_ADDR_TX         = 2'd0;
    localparam logic [1:0] BT_ADDR_STATUS     = 2'd2;
    localparam int         BT_STATUS_BUSY_BIT = 0;

endpackage : bt_seq_pkg

// File: rtl/bt_seq_fifo.sv
// Byte FIFO buffering requester data ahead of the peripheral write sequence.
// Latency: a pushed byte is visible at head_o the cycle after the push edge; head is combinational.
// Backpressure: pushes while full and pops while empty are ignored; full_o tells the producer to stall.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset (pointers and count)
//   push_i/push_dat_i write a byte
//   pop_i             discard the head byte
//   head_o            current head byte
//   full_o/empty_o    occupancy flags
//   count_o           number of stored bytes (0..DEPTH)
module bt_seq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               push_dat_i,
    input  logic                     pop_i,
    output logic [7:0]               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: only slots below the count are ever read as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule : bt_seq_fifo

// File: rtl/bt_tx_sequencer.sv
// Buffers requester bytes and writes each one to peripheral_bt, then polls status until TX is idle.
// Latency: byte accepted at E0 drives per_wr from E1 to E2; minimum 4 cycles per byte.
// Backpressure: tx_ready drops while the FIFO holds FIFO_DEPTH bytes; a same-cycle pop does not raise it.
//
// Optional feature: define BT_SEQ_TIMEOUT_EN to build the busy-poll timeout counter and err_timeout.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready     byte input handshake
//   per_cs/per_addr/per_rd/per_wr/per_d_in   peripheral register bus (Moore, decoded from state)
//   per_d_out                     peripheral read data; bit 0 is TX busy when status is addressed
//   busy                          FIFO non-empty or sequence in progress
//   err_timeout/err_clr           sticky timeout flag and its clear
module bt_tx_sequencer
    import bt_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] per_d_in,
    output logic        per_cs,
    output logic [1:0]  per_addr,
    output logic        per_rd,
    output logic        per_wr,
    input  logic [15:0] per_d_out,
    output logic        busy,
    output logic        err_timeout,
    input  logic        err_clr
);

    bt_state_e state_q, state_d;

    logic                         fifo_push;
    logic                         fifo_pop;
    logic [7:0]                   fifo_head;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_unused;
    logic                         status_busy;
    logic                         to_hit;
    logic                         dout_unused;

    assign tx_ready    = ~fifo_full;
    assign fifo_push   = tx_valid & tx_ready;
    // The byte leaves the FIFO as WRITE ends, so the bus sees it for the whole cycle.
    assign fifo_pop    = (state_q == WRITE);
    assign status_busy = per_d_out[BT_STATUS_BUSY_BIT];
    assign busy        = ~fifo_empty | (state_q != IDLE);
    assign dout_unused = ^per_d_out[15:1];

    bt_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_dat_i (tx_data),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt_unused)
    );

`ifdef BT_SEQ_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;

    // The counter holds the number of earlier busy CHECKs for this byte, so the
    // TIMEOUT_CYCLES-th busy CHECK is the one that sees TO_LAST.
    assign to_hit = (state_q == CHECK) && status_busy && (to_cnt_q >= TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d == WRITE) begin
            to_cnt_d = '0;
        end else if ((state_q == CHECK) && status_busy && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // A new timeout beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (to_hit)       err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    logic clr_unused;

    assign to_hit      = 1'b0;
    assign err_timeout = 1'b0;
    assign clr_unused  = err_clr & (TIMEOUT_CYCLES > 0);
`endif

    // Next-state logic. A timed-out byte is treated as if status had read idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = WRITE;
            WRITE:   state_d = SETTLE;
            SETTLE:  state_d = POLL;
            POLL:    state_d = CHECK;
            CHECK: begin
                if (!status_busy || to_hit) state_d = fifo_empty ? IDLE : WRITE;
                else                        state_d = POLL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Bus decode depends on state only, so asserting rst zeroes the bus immediately.
    always_comb begin
        per_cs   = 1'b0;
        per_rd   = 1'b0;
        per_wr   = 1'b0;
        per_addr = 2'd0;
        per_d_in = 16'h0000;
        case (state_q)
            WRITE: begin
                per_cs   = 1'b1;
                per_wr   = 1'b1;
                per_addr = BT_ADDR_TX;
                per_d_in = {8'h00, fifo_head};
            end
            POLL, CHECK: begin
                per_cs   = 1'b1;
                per_rd   = 1'b1;
                per_addr = BT_ADDR_STATUS;
            end
            default: ;
        endcase
    end

endmodule : bt_tx_sequencer

// File: tb/tb_bt_tx_sequencer.sv
// Self-checking bench for bt_tx_sequencer: directed scenarios plus randomized traffic,
// with a write scoreboard and an occupancy model checked every cycle by a monitor.
module tb_bt_tx_sequencer;

    localparam int DEPTH = 4;
    localparam int TOUT  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] per_d_in;
    logic        per_cs;
    logic [1:0]  per_addr;
    logic        per_rd;
    logic        per_wr;
    logic [15:0] per_d_out = 16'h0000;
    logic        busy;
    logic        err_timeout;
    logic        err_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes written to the peripheral must equal accepted bytes in order;
    // FIFO occupancy = accepted - written (a write leaves the buffer as its cycle ends).
    logic [7:0] exp_q [$];
    int mcnt     = 0;
    int wr_count = 0;
    int rd_count = 0;

    always #5 clk = ~clk;

    bt_tx_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .per_d_in    (per_d_in),
        .per_cs      (per_cs),
        .per_addr    (per_addr),
        .per_rd      (per_rd),
        .per_wr      (per_wr),
        .per_d_out   (per_d_out),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            chk("tx_ready_vs_model", {31'd0, tx_ready}, {31'd0, (mcnt < DEPTH)});
            if (per_cs && per_wr) begin
                wr_count++;
                chk("wr_addr", {30'd0, per_addr}, 32'd0);
                chk("wr_no_rd", {31'd0, per_rd}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", {16'd0, per_d_in}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk("wr_data", {16'd0, per_d_in}, {24'd0, e});
                end
            end else if (per_cs && per_rd) begin
                rd_count++;
                chk("rd_addr", {30'd0, per_addr}, 32'd2);
            end else begin
                chk("bus_idle", {13'd0, per_cs, per_rd, per_wr, per_d_in}, 32'd0);
            end
            if (tx_valid && tx_ready) exp_q.push_back(tx_data);
            mcnt = mcnt + int'(tx_valid && tx_ready) - int'(per_wr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a byte until accepted or max_wait cycles pass.
    task automatic push(input logic [7:0] b, input int max_wait, output bit ok);
        ok       = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) step();
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            #3;
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        bit ok;
        int base_wr;
        int base_rd;
        bit seen;

        // Reset asserted between clock edges: bus must clear without an edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_bus_zero", {13'd0, per_cs, per_rd, per_wr, per_d_in}, 32'd0);
        chk("rst_addr_zero", {30'd0, per_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        step(); step();
        rst = 1'b0;
        #3;
        chk("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Single byte, status idle: WRITE at E1, SETTLE, POLL at E3, CHECK, idle at E5.
        per_d_out = 16'h0000;
        tx_data   = 8'h41;
        tx_valid  = 1'b1;
        step();                      // E0 accepts
        tx_valid = 1'b0;
        #3;
        chk("t2_e0_no_wr", {31'd0, per_wr}, 32'd0);
        chk("t2_e0_busy", {31'd0, busy}, 32'd1);
        step(); #3;                  // E1: WRITE
        chk("t2_e1_wr", {31'd0, per_wr & per_cs}, 32'd1);
        chk("t2_e1_din", {16'd0, per_d_in}, 32'h0041);
        step(); #3;                  // E2: SETTLE
        chk("t2_e2_settle", {29'd0, per_cs, per_rd, per_wr}, 32'd0);
        step(); #3;                  // E3: POLL
        chk("t2_e3_rd", {29'd0, per_cs, per_rd, per_wr}, 32'b110);
        step(); #3;                  // E4: CHECK
        chk("t2_e4_rd", {29'd0, per_cs, per_rd, per_wr}, 32'b110);
        step(); #3;                  // E5: back to idle
        chk("t2_e5_busy", {31'd0, busy}, 32'd0);
        chk("t2_e5_bus", {29'd0, per_cs, per_rd, per_wr}, 32'd0);

        // Busy stuck: 0x10 written, four more queued, 0x15 held off; then drain in order.
        base_wr   = wr_count;
        per_d_out = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            push(8'h10 + 8'(i), 20, ok);
            chk("t3_accept", {31'd0, ok}, 32'd1);
        end
        push(8'h15, 12, ok);
        chk("t3_full_stall", {31'd0, ok}, 32'd0);
        chk("t3_one_write", wr_count - base_wr, 32'd1);
        per_d_out = 16'h0000;
        push(8'h15, 60, ok);
        chk("t3_accept_15", {31'd0, ok}, 32'd1);
        wait_idle(200, "t3_drain");
        chk("t3_all_written", wr_count - base_wr, 32'd6);
        chk("t3_sb_empty", exp_q.size(), 32'd0);

`ifdef BT_SEQ_TIMEOUT_EN
        // Timeout: TOUT busy CHECKs abandon 0xA0, then 0xA1 is written.
        per_d_out = 16'h0001;
        base_rd   = rd_count;
        push(8'hA0, 10, ok);
        push(8'hA1, 10, ok);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(); #3;
            if (err_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t4_err_set", {31'd0, seen}, 32'd1);
        chk("t4_rd_cycles", rd_count - base_rd, 2 * TOUT);
        chk("t4_next_write", {15'd0, per_wr, per_d_in}, 32'h1_00A1);
        per_d_out = 16'h0000;
        wait_idle(100, "t4_drain");
        chk("t4_err_sticky", {31'd0, err_timeout}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #3;
        chk("t4_err_cleared", {31'd0, err_timeout}, 32'd0);
`else
        // No timeout logic: busy stuck for 1000 cycles keeps polling.
        per_d_out = 16'hFFFF;
        push(8'hB0, 10, ok);
        for (int i = 0; i < 6; i++) step();
        #3;
        base_rd = rd_count;
        for (int i = 0; i < 1000; i++) step();
        #3;
        chk("t6_poll_all_cycles", rd_count - base_rd, 32'd1000);
        chk("t6_err_zero", {31'd0, err_timeout}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        err_clr = 1'b1;
        step(); #3;
        chk("t6_err_clr_ignored", {31'd0, err_timeout}, 32'd0);
        err_clr   = 1'b0;
        per_d_out = 16'h0000;
        wait_idle(100, "t6_drain");
`endif

        // Reset during CHECK with three bytes queued.
        per_d_out = 16'h0001;
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 20, ok);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(); #3;
            if (per_rd) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t5_reach_poll", {31'd0, seen}, 32'd1);
        step();                      // now in CHECK
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_bus", {13'd0, per_cs, per_rd, per_wr, per_d_in}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        step(); step();
        rst       = 1'b0;
        per_d_out = 16'h0000;
        base_wr   = wr_count;
        for (int i = 0; i < 20; i++) step();
        #3;
        chk("t5_no_write", wr_count - base_wr, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, tx_ready}, 32'd1);

        // Random traffic with random busy and junk in the upper status bits.
        for (int i = 0; i < 600; i++) begin
            tx_valid  = ($urandom_range(0, 1) == 1);
            tx_data   = 8'($urandom);
            per_d_out = {15'($urandom), ($urandom_range(0, 9) < 3)};
            step();
        end
        tx_valid  = 1'b0;
        per_d_out = 16'h0000;
        wait_idle(400, "rand_drain");
        chk("rand_sb_empty", exp_q.size(), 32'd0);
        chk("rand_model_cnt", mcnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_bt_tx_sequencer
